// File: rtl/lsu_dccm_arb_pkg.sv
// ---------------------------------------------------------------------------
// lsu_dccm_arb_pkg
// Shared definitions for the LSU / store-buffer / DMA arbiter in front of the
// DCCM:
//   - default widths and the default starvation limit
//   - the arbiter FSM state encoding
//   - the one-hot grant bundle and the priority picker used by the top level
// ---------------------------------------------------------------------------
package lsu_dccm_arb_pkg;

    localparam int DCCM_BITS_DEFAULT   = 16;
    localparam int FDATA_WIDTH_DEFAULT = 39;
    localparam int STARVE_MAX_DEFAULT  = 7;
    localparam int WAIT_CNT_W          = 4;

    // Arbiter priority modes. NORMAL favours loads; each boost state lifts
    // one starved or urgent requester to the top until it is served.
    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        DMA_BOOST = 2'd1,
        ST_BOOST  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic ld;
        logic st;
        logic dma;
    } arb_gnt_t;

    // Fixed-priority pick for the current mode; returns at most one grant.
    function automatic arb_gnt_t pick_grant(
        input arb_state_e state,
        input logic       ld_req,
        input logic       st_req,
        input logic       dma_req
    );
        arb_gnt_t g;
        g = '0;
        case (state)
            DMA_BOOST: begin
                if (dma_req)     g.dma = 1'b1;
                else if (ld_req) g.ld  = 1'b1;
                else if (st_req) g.st  = 1'b1;
            end
            ST_BOOST: begin
                if (st_req)       g.st  = 1'b1;
                else if (ld_req)  g.ld  = 1'b1;
                else if (dma_req) g.dma = 1'b1;
            end
            default: begin
                if (ld_req)       g.ld  = 1'b1;
                else if (dma_req) g.dma = 1'b1;
                else if (st_req)  g.st  = 1'b1;
            end
        endcase
        return g;
    endfunction

endpackage

// File: rtl/lsu_dccm_arb_if.sv
// ---------------------------------------------------------------------------
// lsu_dccm_arb_if
// Bundles every requester and memory-side signal of the DCCM arbiter.
//   slave  : the arbiter's view (requests/payloads/read data in, grants and
//            memory controls out)
//   master : the surrounding core's view (requesters plus the DCCM macro)
// Parameters:
//   DCCM_BITS   - DCCM byte-address width
//   FDATA_WIDTH - DCCM data width including ECC
// ---------------------------------------------------------------------------
interface lsu_dccm_arb_if
    import lsu_dccm_arb_pkg::*;
#(
    parameter int DCCM_BITS   = DCCM_BITS_DEFAULT,
    parameter int FDATA_WIDTH = FDATA_WIDTH_DEFAULT
);

    logic                   lsu_freeze_dc3;

    logic                   ld_req;
    logic [DCCM_BITS-1:0]   ld_addr_lo;
    logic [DCCM_BITS-1:0]   ld_addr_hi;
    logic                   ld_gnt;

    logic                   st_req;
    logic                   st_full;
    logic [DCCM_BITS-1:0]   st_addr;
    logic [FDATA_WIDTH-1:0] st_data;
    logic                   st_gnt;

    logic                   dma_req;
    logic                   dma_write;
    logic [DCCM_BITS-1:0]   dma_addr;
    logic [FDATA_WIDTH-1:0] dma_wdata;
    logic                   dma_gnt;
    logic                   dma_rvalid;
    logic [FDATA_WIDTH-1:0] dma_rdata;

    logic                   dccm_wren;
    logic                   dccm_rden;
    logic [DCCM_BITS-1:0]   dccm_wr_addr;
    logic [DCCM_BITS-1:0]   dccm_rd_addr_lo;
    logic [DCCM_BITS-1:0]   dccm_rd_addr_hi;
    logic [FDATA_WIDTH-1:0] dccm_wr_data;
    logic [FDATA_WIDTH-1:0] dccm_rd_data_lo;

    modport slave (
        input  lsu_freeze_dc3,
        input  ld_req, ld_addr_lo, ld_addr_hi,
        output ld_gnt,
        input  st_req, st_full, st_addr, st_data,
        output st_gnt,
        input  dma_req, dma_write, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output dccm_wren, dccm_rden, dccm_wr_addr,
        output dccm_rd_addr_lo, dccm_rd_addr_hi, dccm_wr_data,
        input  dccm_rd_data_lo
    );

    modport master (
        output lsu_freeze_dc3,
        output ld_req, ld_addr_lo, ld_addr_hi,
        input  ld_gnt,
        output st_req, st_full, st_addr, st_data,
        input  st_gnt,
        output dma_req, dma_write, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  dccm_wren, dccm_rden, dccm_wr_addr,
        input  dccm_rd_addr_lo, dccm_rd_addr_hi, dccm_wr_data,
        output dccm_rd_data_lo
    );

endinterface

// File: rtl/lsu_dccm_arb_starve.sv
// ---------------------------------------------------------------------------
// lsu_dccm_arb_starve
// Starvation wait counter for one requester of the DCCM arbiter.
// Ports:
//   clk, rst_l - core clock, asynchronous active-low reset
//   freeze     - pipe freeze; a frozen cycle does not count as waiting
//   req, gnt   - the requester's request and this cycle's grant
//   starved    - the counter holds STARVE_MAX after this cycle's update
// The counter counts unfrozen cycles spent requesting without a grant,
// saturates at STARVE_MAX, and clears on a grant or a dropped request.
// ---------------------------------------------------------------------------
module lsu_dccm_arb_starve
    import lsu_dccm_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic clk,
    input  logic rst_l,
    input  logic freeze,
    input  logic req,
    input  logic gnt,
    output logic starved
);

    localparam logic [WAIT_CNT_W-1:0] MAX_CNT = WAIT_CNT_W'(STARVE_MAX);

    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [WAIT_CNT_W-1:0] wait_cnt_nxt;

    always_comb begin
        wait_cnt_nxt = wait_cnt;
        if (!req || gnt) begin
            wait_cnt_nxt = '0;
        end else if (!freeze && (wait_cnt < MAX_CNT)) begin
            wait_cnt_nxt = wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Looking at the updated value lets the FSM enter its boost state on the
    // same edge the counter reaches the limit, so the starved requester is
    // served in the very next cycle instead of one cycle later.
    assign starved = (wait_cnt_nxt == MAX_CNT);

endmodule

// File: rtl/lsu_dccm_arb.sv
// ---------------------------------------------------------------------------
// lsu_dccm_arb
// Arbitrates the single DCCM port between LSU loads, store-buffer writes and
// DMA reads/writes.
// Ports:
//   clk   - core clock
//   rst_l - asynchronous active-low reset
//   bus   - lsu_dccm_arb_if.slave: freeze, the three request/payload/grant
//           groups, the DMA read-return path and the DCCM memory controls
// Parameters:
//   DCCM_BITS, FDATA_WIDTH - address and data (with ECC) widths
//   STARVE_MAX             - wait cycles before a starved requester is
//                            promoted (1..15)
// Grants are combinational from the requests and the priority mode; the mode
// FSM, two starvation counters and the DMA read-return flag are registered.
// ---------------------------------------------------------------------------
module lsu_dccm_arb
    import lsu_dccm_arb_pkg::*;
#(
    parameter int DCCM_BITS   = DCCM_BITS_DEFAULT,
    parameter int FDATA_WIDTH = FDATA_WIDTH_DEFAULT,
    parameter int STARVE_MAX  = STARVE_MAX_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_l,
    lsu_dccm_arb_if.slave  bus
);

    arb_state_e             state_q;
    arb_gnt_t               gnt;
    logic                   arb_en;
    logic                   dma_starved;
    logic                   st_starved;
    logic                   st_urgent;
    logic                   dma_rvalid_q;

    logic                   rden;
    logic                   wren;
    logic [DCCM_BITS-1:0]   rd_addr_lo;
    logic [DCCM_BITS-1:0]   rd_addr_hi;
    logic [DCCM_BITS-1:0]   wr_addr;
    logic [FDATA_WIDTH-1:0] wr_data;

    // Grants are suppressed while frozen and while reset is held, so every
    // output is quiet during reset even if requesters keep asserting.
    assign arb_en = rst_l & ~bus.lsu_freeze_dc3;

    always_comb begin
        gnt = '0;
        if (arb_en) begin
            gnt = pick_grant(state_q, bus.ld_req, bus.st_req, bus.dma_req);
        end
    end

    lsu_dccm_arb_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_dma_starve (
        .clk     (clk),
        .rst_l   (rst_l),
        .freeze  (bus.lsu_freeze_dc3),
        .req     (bus.dma_req),
        .gnt     (gnt.dma),
        .starved (dma_starved)
    );

    lsu_dccm_arb_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_st_starve (
        .clk     (clk),
        .rst_l   (rst_l),
        .freeze  (bus.lsu_freeze_dc3),
        .req     (bus.st_req),
        .gnt     (gnt.st),
        .starved (st_starved)
    );

    // A full store buffer needs draining right away, not after a starvation
    // period, so it is as urgent as a starved store.
    assign st_urgent = st_starved | (bus.st_full & bus.st_req);

    // Priority-mode FSM. A boost state is held until its requester is served
    // or withdraws; on exit the other requester's boost condition is
    // honoured directly so it does not have to pass through NORMAL first.
    // DMA starvation outranks store urgency when both arise from NORMAL.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= NORMAL;
        end else begin
            case (state_q)
                NORMAL: begin
                    if (dma_starved)    state_q <= DMA_BOOST;
                    else if (st_urgent) state_q <= ST_BOOST;
                end
                DMA_BOOST: begin
                    if (gnt.dma || !bus.dma_req) begin
                        state_q <= st_urgent ? ST_BOOST : NORMAL;
                    end
                end
                ST_BOOST: begin
                    if (gnt.st || !bus.st_req) begin
                        state_q <= dma_starved ? DMA_BOOST : NORMAL;
                    end
                end
                default: state_q <= NORMAL;
            endcase
        end
    end

    // Steer the winner's address and data onto the DCCM port. A DMA read
    // uses the same address on both banks since it is always aligned.
    always_comb begin
        rden       = 1'b0;
        wren       = 1'b0;
        rd_addr_lo = '0;
        rd_addr_hi = '0;
        wr_addr    = '0;
        wr_data    = '0;
        if (gnt.ld) begin
            rden       = 1'b1;
            rd_addr_lo = bus.ld_addr_lo;
            rd_addr_hi = bus.ld_addr_hi;
        end else if (gnt.st) begin
            wren    = 1'b1;
            wr_addr = bus.st_addr;
            wr_data = bus.st_data;
        end else if (gnt.dma) begin
            if (bus.dma_write) begin
                wren    = 1'b1;
                wr_addr = bus.dma_addr;
                wr_data = bus.dma_wdata;
            end else begin
                rden       = 1'b1;
                rd_addr_lo = bus.dma_addr;
                rd_addr_hi = bus.dma_addr;
            end
        end
    end

    // The DCCM returns read data one cycle after the enable. The response is
    // delivered even if freeze rises meanwhile; only reset discards it.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            dma_rvalid_q <= 1'b0;
        end else begin
            dma_rvalid_q <= gnt.dma & ~bus.dma_write;
        end
    end

    assign bus.ld_gnt          = gnt.ld;
    assign bus.st_gnt          = gnt.st;
    assign bus.dma_gnt         = gnt.dma;
    assign bus.dma_rvalid      = dma_rvalid_q;
    assign bus.dma_rdata       = dma_rvalid_q ? bus.dccm_rd_data_lo : '0;
    assign bus.dccm_rden       = rden;
    assign bus.dccm_wren       = wren;
    assign bus.dccm_rd_addr_lo = rd_addr_lo;
    assign bus.dccm_rd_addr_hi = rd_addr_hi;
    assign bus.dccm_wr_addr    = wr_addr;
    assign bus.dccm_wr_data    = wr_data;

endmodule

// File: doc/lsu_dccm_arb.md
LSU_DCCM_ARB -- requirements
Module: lsu_dccm_arb

Interface
REQ-001 SHALL have parameter DCCM_BITS, default 16, DCCM byte-address width.
REQ-002 SHALL have parameter FDATA_WIDTH, default 39, DCCM data width including ECC.
REQ-003 SHALL have parameter STARVE_MAX, default 7, wait cycles before a starved requester is promoted; legal range 1-15.
REQ-004 SHALL use one clock and an asynchronous active-low reset, as these ports:
- clk  in  1  core clock.
- rst_l  in  1  asynchronous active-low reset.
- lsu_freeze_dc3  in  1  pipe freeze.
- ld_req  in  1  LSU load read request.
- ld_addr_lo  in  DCCM_BITS  load low-bank address.
- ld_addr_hi  in  DCCM_BITS  load high-bank address (misaligned access).
- ld_gnt  out  1  load granted this cycle.
- st_req  in  1  store-buffer write request.
- st_full  in  1  store buffer full.
- st_addr  in  DCCM_BITS  store write address.
- st_data  in  FDATA_WIDTH  store write data.
- st_gnt  out  1  store granted.
- dma_req  in  1  DMA request.
- dma_write  in  1  1 = DMA write, 0 = DMA read.
- dma_addr  in  DCCM_BITS  DMA address.
- dma_wdata  in  FDATA_WIDTH  DMA write data.
- dma_gnt  out  1  DMA granted.
- dma_rvalid  out  1  DMA read data valid.
- dma_rdata  out  FDATA_WIDTH  DMA read data.
- dccm_wren, dccm_rden  out  1 each  memory enables.
- dccm_wr_addr, dccm_rd_addr_lo, dccm_rd_addr_hi  out  DCCM_BITS each  memory addresses.
- dccm_wr_data  out  FDATA_WIDTH  memory write data.
- dccm_rd_data_lo  in  FDATA_WIDTH  memory low read data.

Function
REQ-005 SHALL assert at most one of ld_gnt/st_gnt/dma_gnt per cycle; grants are combinational from requests and state.
REQ-006 SHALL assert no grant and drive dccm_wren = dccm_rden = 0 while lsu_freeze_dc3 = 1.
REQ-007 SHALL hold a 3-state FSM (NORMAL, DMA_BOOST, ST_BOOST) that sets priority:
- NORMAL: ld > dma > st.
- DMA_BOOST: dma > ld > st.
- ST_BOOST: st > ld > dma.
REQ-008 SHALL keep dma_wait_cnt (4 bits):
- +1 each unfrozen cycle with dma_req & ~dma_gnt, saturating at STARVE_MAX.
- cleared on dma_gnt or when dma_req = 0.
REQ-009 SHALL keep st_wait_cnt with the same rules applied to st_req/st_gnt.
REQ-010 SHALL transition NORMAL -> DMA_BOOST when dma_wait_cnt == STARVE_MAX.
REQ-011 SHALL otherwise transition NORMAL -> ST_BOOST when st_wait_cnt == STARVE_MAX or st_full & st_req; DMA wins if both conditions hold.
REQ-012 SHALL leave a boost state only on a grant to the boosted requester, or on deassertion of its request. The next state is then ST_BOOST if the store condition holds (from DMA_BOOST), DMA_BOOST if the DMA condition holds (from ST_BOOST), else NORMAL.
REQ-013 SHALL drive memory outputs for the granted requester:
- load: dccm_rden = 1, rd_addr_lo/hi = ld_addr_lo/hi.
- store: dccm_wren = 1, wr_addr = st_addr, wr_data = st_data.
- DMA read: dccm_rden = 1, rd_addr_lo = rd_addr_hi = dma_addr.
- DMA write: dccm_wren = 1, wr_addr = dma_addr, wr_data = dma_wdata.
- no grant: all memory outputs 0.
REQ-014 SHALL assert dma_rvalid exactly one cycle after a DMA read grant, regardless of freeze, with dma_rdata = dccm_rd_data_lo in that cycle. dma_rdata = 0 when dma_rvalid = 0.
REQ-015 SHALL require requesters to hold req and payload stable until granted; dma_write sampled only at grant.

Reset
REQ-016 SHALL on rst_l = 0 asynchronously set FSM = NORMAL, both counters = 0, dma_rvalid = 0. All outputs are 0 during reset.
REQ-017 SHALL, when reset asserts the cycle after a DMA read grant, drop that pending response (no dma_rvalid after reset).

Structure
REQ-018 SHALL place the FSM state encoding and the STARVE_MAX default in the shared global header.
REQ-019 SHALL implement each wait counter as one sub-module, lsu_dccm_arb_starve, instantiated twice; all flops use the codebase's standard flop cells.

Verification
REQ-020 SHALL cover these directed scenarios (STARVE_MAX = 7):
- ld_req, dma_req, st_req all held high -> ld_gnt for 7 cycles, dma_gnt on cycle 8, then ld_gnt resumes; st_gnt once st_wait_cnt reaches 7.
- DMA read at dma_addr = 0x0040 with the memory returning 0x1A5A5A5A5 -> dma_gnt, dccm_rden = 1, rd_addr_lo = rd_addr_hi = 0x0040; next cycle dma_rvalid = 1, dma_rdata = 0x1A5A5A5A5.
- st_full = 1 with st_req and ld_req high -> st_gnt the cycle after the request, dccm_wren = 1, ld_gnt = 0 that cycle.
- lsu_freeze_dc3 = 1 for 3 cycles with all requests high -> no grants, enables 0, counters unchanged; arbitration resumes on unfreeze.
- rst_l pulsed low in the cycle after a DMA read grant while in DMA_BOOST -> dma_rvalid stays 0, FSM = NORMAL, counters = 0.
- Misaligned load with ld_addr_lo = 0x0004 and ld_addr_hi = 0x0008 -> dccm_rden = 1 with both addresses passed unchanged, ld_gnt = 1, dccm_wren = 0.
